score_bcd: RTL and testbench
============================

# score_bcd

Game-score accumulator and binary-to-BCD converter feeding the seven-segment display path. It counts food-eaten events from the snake game logic into a 7-bit binary score. Each time the score changes, it runs a sequential shift-add-3 (double-dabble) conversion and presents the two-digit packed BCD result on `bcd_data` for the 74HC595 display driver stage.

## Interface
- `SCORE_MAX`, default 99: maximum score value; legal range 1..99.
- `sys_clk` in 1: system clock; all logic is on the rising edge.
- `sys_rst_n` in 1: asynchronous active-low reset.
- `eat_in` in 1: food-eaten strobe from game logic; level signal, rising-edge counted.
- `clear_signal` in 1: synchronous score clear (game restart / game over), active-high.
- `bcd_data` out 8: packed BCD score; [7:4] is tens, [3:0] is units; registered.
- `bcd_valid` out 1: one-cycle pulse when `bcd_data` has just been updated.
- `busy` out 1: high while a conversion is in progress (state CONV or DONE).

## Operation
- Edge detect:
  - `eat_d` registers `eat_in`.
  - Increment event = `eat_in & ~eat_d`.
  - An input held high for N cycles counts once.
- Score register, 7 bits:
  - Clear: when `clear_signal` is high, score <= 0 and pend <= 1. Clear has priority over a simultaneous increment event.
  - Increment: score <= score+1 and pend <= 1.
  - Wrap: at score == SCORE_MAX, an increment wraps to 0 (see Configuration).
- FSM states: IDLE, CONV, DONE.
  - IDLE & pend: go to CONV. Load shift register {tens, units, bin} = {4'h0, 4'h0, score}, set cnt <= 0, clear pend.
  - CONV, each cycle:
    - Add 3 to every BCD nibble that is >= 5.
    - Then shift the 15-bit register left by 1.
    - cnt++.
    - After the 7th shift (cnt == 6 when shifting), go to DONE.
  - DONE: bcd_data <= BCD nibbles, bcd_valid <= 1, go to IDLE.
- Events arriving during CONV/DONE:
  - They update score and set pend.
  - The running conversion completes with its loaded snapshot.
  - A new conversion starts from IDLE on the next cycle.
  - Multiple pending changes coalesce into one conversion of the latest score.
- `clear_signal` during CONV or DONE:
  - Aborts the conversion: state <= IDLE, no `bcd_valid` pulse, `bcd_data` is not written.
  - Sets pend, so 0x00 is converted next.
- BCD nibbles never exceed 9 for any score 0..99.

## Timing
- Reset values: score 0, eat_d 0, pend 0, state IDLE, cnt 0, `bcd_data` 8'h00, `bcd_valid` 0, `busy` 0.
- Reset is asynchronous mid-conversion; it returns everything to the reset values immediately.
- Latency, with the increment event sampled at edge k:
  - score updates at k.
  - Load at k+1.
  - Shifts at k+2..k+8.
  - `bcd_data` and `bcd_valid` update at k+9.
  - `bcd_valid` falls at k+10.
- `busy` is high from edge k+1 through edge k+9, i.e. while in CONV or DONE.
- Back-to-back: with pend set during a conversion, the next load occurs the edge after DONE (IDLE lasts one cycle).
- `bcd_data` holds its value between updates; there are no glitches between `bcd_valid` pulses.

## Configuration
- `SCORE_SATURATE_EN` defined:
  - Score saturates at SCORE_MAX; increments at SCORE_MAX are ignored.
  - pend is not set when the score value does not change.
- `SCORE_SATURATE_EN` undefined:
  - SCORE_MAX + 1 wraps to 0, sets pend, and displays 0x00.

## Test plan
- Reset release, no events: `bcd_data` == 8'h00, `bcd_valid` never pulses, `busy` == 0.
- Single `eat_in` pulse at edge k: `bcd_valid` high exactly at k+9 for one cycle, `bcd_data` == 8'h01. Holding `eat_in` high 20 cycles yields one increment only.
- 47 separated pulses, each >= 12 cycles apart: final `bcd_data` == 8'h47, with 47 `bcd_valid` pulses and every intermediate value correct BCD.
- 3 pulses spaced 2 cycles apart starting from 0: exactly 2 conversions; final `bcd_data` == 8'h03.
- `clear_signal` asserted 4 cycles into a conversion of score 12: no pulse for 12; next `bcd_valid` shows 8'h00. `clear_signal` and an eat edge in the same cycle give score 0.
- Score 99 plus one eat: 8'h00 with the macro undefined; 8'h99 and no `bcd_valid` pulse with `SCORE_SATURATE_EN`.

Source files
------------

// File: rtl/score_bcd.sv
// score_bcd: food-eaten score counter with sequential double-dabble BCD conversion.
// Define SCORE_SATURATE_EN to hold the score at SCORE_MAX instead of wrapping to 0.
module score_bcd #(
    parameter int SCORE_MAX = 99
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       eat_in,
    input  logic       clear_signal,
    output logic [7:0] bcd_data,
    output logic       bcd_valid,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t      r_state;
    logic        r_eat_d;
    logic        r_pend;
    logic [6:0]  r_score;
    logic [2:0]  r_cnt;
    logic [14:0] r_shift;
    logic        w_inc;
    logic        w_max;
    logic        w_bump;
    logic [14:0] w_adj;
    assign w_inc = eat_in & ~r_eat_d;
    assign w_max = r_score == 7'(SCORE_MAX);
`ifdef SCORE_SATURATE_EN
    assign w_bump = w_inc & ~w_max;
`else
    assign w_bump = w_inc;
`endif
    assign w_adj = {r_shift[14:11] >= 4'd5 ? r_shift[14:11] + 4'd3 : r_shift[14:11],
                    r_shift[10:7]  >= 4'd5 ? r_shift[10:7]  + 4'd3 : r_shift[10:7],
                    r_shift[6:0]};
    assign busy = r_state != IDLE;
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= IDLE;
            r_eat_d   <= 1'b0;
            r_pend    <= 1'b0;
            r_score   <= 7'd0;
            r_cnt     <= 3'd0;
            r_shift   <= 15'd0;
            bcd_data  <= 8'h00;
            bcd_valid <= 1'b0;
        end else begin
            r_eat_d   <= eat_in;
            bcd_valid <= 1'b0;
            if (clear_signal) begin
                // abort any conversion in flight; the cleared score is converted next
                r_score <= 7'd0;
                r_pend  <= 1'b1;
                r_state <= IDLE;
            end else begin
                if (w_bump) r_score <= w_max ? 7'd0 : r_score + 7'd1;
                r_pend <= w_bump | (r_pend & (r_state != IDLE));
                case (r_state)
                    IDLE: if (r_pend) begin
                        r_shift <= {8'h00, r_score};
                        r_cnt   <= 3'd0;
                        r_state <= CONV;
                    end
                    CONV: begin
                        r_shift <= {w_adj[13:0], 1'b0};
                        r_cnt   <= r_cnt + 3'd1;
                        if (r_cnt == 3'd6) r_state <= DONE;
                    end
                    DONE: begin
                        bcd_data  <= r_shift[14:7];
                        bcd_valid <= 1'b1;
                        r_state   <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_score_bcd.sv
// tb_score_bcd: randomized and directed checks of score_bcd against a cycle-level
// reference model built from decimal arithmetic.
module tb_score_bcd;
    localparam int MAX = 99;
    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       eat_in = 1'b0;
    logic       clear_signal = 1'b0;
    logic [7:0] bcd_data;
    logic       bcd_valid;
    logic       busy;
    int n_vec = 0;
    int n_err = 0;
    int pulses = 0;
    int m_score, m_phase, m_snap;
    bit m_pend, m_prev, m_valid;
    logic [7:0] m_data;

    score_bcd #(.SCORE_MAX(MAX)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .eat_in(eat_in),
        .clear_signal(clear_signal), .bcd_data(bcd_data),
        .bcd_valid(bcd_valid), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + v % 10);
    endfunction

    // predicts the state after the next rising edge, given the inputs just driven
    task automatic advance(input bit e, input bit c);
        bit inc;
        inc = e && !m_prev;
        m_prev = e;
        m_valid = 1'b0;
        if (c) begin
            m_score = 0;
            m_pend = 1'b1;
            m_phase = 0;
        end else begin
            if (m_phase == 0) begin
                if (m_pend) begin
                    m_snap = m_score;
                    m_pend = 1'b0;
                    m_phase = 1;
                end
            end else if (m_phase == 8) begin
                m_data = to_bcd(m_snap);
                m_valid = 1'b1;
                m_phase = 0;
            end else begin
                m_phase++;
            end
            if (inc) begin
`ifdef SCORE_SATURATE_EN
                if (m_score < MAX) begin
                    m_score++;
                    m_pend = 1'b1;
                end
`else
                m_score = (m_score + 1) % (MAX + 1);
                m_pend = 1'b1;
`endif
            end
        end
    endtask

    task automatic step(input bit e, input bit c);
        @(negedge sys_clk);
        check("valid", bcd_valid, m_valid);
        check("data", bcd_data, m_data);
        check("busy", busy, m_phase != 0);
        if (bcd_valid) pulses++;
        eat_in = e;
        clear_signal = c;
        advance(e, c);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic pulse();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        eat_in = 1'b0;
        clear_signal = 1'b0;
        m_score = 0; m_phase = 0; m_snap = 0;
        m_pend = 1'b0; m_prev = 1'b0; m_valid = 1'b0; m_data = 8'h00;
        @(negedge sys_clk);
        check("rst_data", bcd_data, 8'h00);
        check("rst_valid", bcd_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        advance(1'b0, 1'b0);
    endtask

    initial begin
        int base, lat;
        do_reset();
        idle(10);
        check("idle_pulses", pulses, 0);
        check("idle_data", bcd_data, 8'h00);

        base = pulses;
        step(1'b1, 1'b0);
        lat = 0;
        for (int i = 1; i <= 15; i++) begin
            step(1'b0, 1'b0);
            if (bcd_valid && lat == 0) lat = i;
        end
        check("latency", lat, 10);
        check("one_cnt", pulses - base, 1);
        check("one_data", bcd_data, 8'h01);

        base = pulses;
        repeat (20) step(1'b1, 1'b0);
        idle(12);
        check("hold_cnt", pulses - base, 1);
        check("hold_data", bcd_data, 8'h02);

        step(1'b1, 1'b0);
        idle(5);
        do_reset();
        idle(12);
        check("midrst_data", bcd_data, 8'h00);

        base = pulses;
        repeat (47) begin
            pulse();
            idle(10);
        end
        idle(12);
        check("p47_cnt", pulses - base, 47);
        check("p47_data", bcd_data, 8'h47);

        do_reset();
        base = pulses;
        repeat (3) pulse();
        idle(20);
        check("b2b_cnt", pulses - base, 2);
        check("b2b_data", bcd_data, 8'h03);

        do_reset();
        repeat (11) begin
            pulse();
            idle(10);
        end
        base = pulses;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b1);
        idle(15);
        check("clr_cnt", pulses - base, 1);
        check("clr_data", bcd_data, 8'h00);

        base = pulses;
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        idle(15);
        check("clreat_cnt", pulses - base, 1);
        check("clreat_data", bcd_data, 8'h00);
        pulse();
        idle(12);
        check("clreat_next", bcd_data, 8'h01);

        do_reset();
        repeat (99) begin
            pulse();
            idle(10);
        end
        check("max_data", bcd_data, 8'h99);
        base = pulses;
        pulse();
        idle(12);
`ifdef SCORE_SATURATE_EN
        check("sat_cnt", pulses - base, 0);
        check("sat_data", bcd_data, 8'h99);
`else
        check("wrap_cnt", pulses - base, 1);
        check("wrap_data", bcd_data, 8'h00);
`endif

        do_reset();
        repeat (3000) step($urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0);
        idle(12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
